// File: rtl/maple_rx_decoder_if.sv
// Byte stream interface between the Maple RX decoder and the RX FIFO.
// Carries one 8-bit AXI4-Stream channel with TLAST.
interface maple_rx_decoder_if;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tlast;
  logic       tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/maple_rx_decoder.sv
// Maple Bus line decoder: synchronises SDCKA/SDCKB, recognises start/end patterns,
// deserialises MSB-first bytes and streams them out with TLAST on the last byte.
// One byte is held back (HOLD) so that the final byte can be tagged TLAST at END.
// Optional feature macro: MAPLE_RX_CRC_EN (packet XOR check driving crc_err).
module maple_rx_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               enable,
  input  logic               sdcka,
  input  logic               sdckb,
  maple_rx_decoder_if.master m_axis,
  output logic               receiving,
  output logic               frame_err,
  output logic               overrun,
  output logic               crc_err
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA_A = 3'd2,
    ST_DATA_B = 3'd3,
    ST_END    = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d;
  logic                   a_prev_q, b_prev_q;
  logic                   a_s, b_s, a_fall_s, a_rise_s, b_fall_s, b_rise_s, a_edge_s, b_edge_s;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          out_vld_q, out_vld_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          receiving_q, receiving_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          active_s, tmo_hit_s, out_free_s, in_bit_s, byte_done_s;
  logic [7:0]    byte_s;

  // Shift registers of the line synchronisers.
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], sdcka};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], sdckb};
  end

  // Synchroniser and previous-sample flops; idle-high lines reset to 1 to avoid false edges.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      a_sync_q <= {SYNC_STAGES{1'b1}};
      b_sync_q <= {SYNC_STAGES{1'b1}};
      a_prev_q <= 1'b1;
      b_prev_q <= 1'b1;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      a_prev_q <= a_sync_q[SYNC_STAGES-1];
      b_prev_q <= b_sync_q[SYNC_STAGES-1];
    end
  end

  assign a_s        = a_sync_q[SYNC_STAGES-1];
  assign b_s        = b_sync_q[SYNC_STAGES-1];
  assign a_fall_s   = a_prev_q & ~a_s;
  assign a_rise_s   = ~a_prev_q & a_s;
  assign b_fall_s   = b_prev_q & ~b_s;
  assign b_rise_s   = ~b_prev_q & b_s;
  assign a_edge_s   = a_prev_q ^ a_s;
  assign b_edge_s   = b_prev_q ^ b_s;
  assign active_s   = (state_q == ST_START) || (state_q == ST_DATA_A) ||
                      (state_q == ST_DATA_B) || (state_q == ST_END);
  assign tmo_hit_s  = (tmo_q == TMO_MAX);
  // OUT can accept a new byte if empty or being consumed this cycle.
  assign out_free_s = ~out_vld_q | m_axis.tready;

  // Next-state, deserialiser, HOLD/OUT buffering and error pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    receiving_d = receiving_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done_s = 1'b0;
    in_bit_s    = (state_q == ST_DATA_A) ? b_s : a_s;
    byte_s      = {shift_q, in_bit_s};

    if (out_vld_q && m_axis.tready) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end

    if (!active_s || a_edge_s || b_edge_s) begin
      tmo_d = {TW{1'b0}};
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    if (active_s && !enable) begin
      // Enable dropped mid-packet: close framing quietly.
      state_d = ST_FLUSH;
    end else if (active_s && ((a_edge_s && b_edge_s) || tmo_hit_s)) begin
      state_d     = ST_FLUSH;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d    = 3'd0;
          bitcnt_d = 3'd0;
          shift_d  = 7'd0;
          if (enable && a_fall_s && b_s) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (a_rise_s) begin
            if (cnt_q == 3'd4) begin
              state_d     = ST_DATA_A;
              receiving_d = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              frame_err_d = 1'b1;
            end
          end else if (b_fall_s) begin
            cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_DATA_A: begin
          if (a_fall_s) begin
            shift_d     = byte_s[6:0];
            bitcnt_d    = bitcnt_q + 3'd1;
            byte_done_s = (bitcnt_q == 3'd7);
            state_d     = ST_DATA_B;
          end else if (b_fall_s && a_s) begin
            cnt_d = 3'd0;
            if (bitcnt_q == 3'd0) begin
              state_d = ST_END;
            end else begin
              state_d     = ST_FLUSH;
              frame_err_d = 1'b1;
            end
          end else begin
            state_d = ST_DATA_A;
          end
        end
        ST_DATA_B: begin
          if (b_fall_s) begin
            shift_d     = byte_s[6:0];
            bitcnt_d    = bitcnt_q + 3'd1;
            byte_done_s = (bitcnt_q == 3'd7);
            state_d     = ST_DATA_A;
          end else begin
            state_d = ST_DATA_B;
          end
        end
        ST_END: begin
          if (b_rise_s) begin
            state_d     = ST_FLUSH;
            frame_err_d = (cnt_q != 3'd2);
          end else if (a_fall_s && !b_s) begin
            cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_FLUSH: begin
          if (!hold_vld_q) begin
            state_d     = ST_IDLE;
            receiving_d = 1'b0;
          end else if (out_free_s) begin
            out_data_d  = hold_q;
            out_last_d  = 1'b1;
            out_vld_d   = 1'b1;
            hold_vld_d  = 1'b0;
            receiving_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A completed byte parks in HOLD; a full HOLD is pushed to OUT (tlast=0) first.
    if (byte_done_s) begin
      if (!hold_vld_q) begin
        hold_d     = byte_s;
        hold_vld_d = 1'b1;
      end else if (out_free_s) begin
        out_data_d = hold_q;
        out_last_d = 1'b0;
        out_vld_d  = 1'b1;
        hold_d     = byte_s;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = 1'b0;
    end
  end

  // Main state, buffer and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      bitcnt_q    <= 3'd0;
      hold_q      <= 8'd0;
      hold_vld_q  <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      tmo_q       <= {TW{1'b0}};
      receiving_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_vld_q   <= out_vld_d;
      tmo_q       <= tmo_d;
      receiving_q <= receiving_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;
  assign receiving     = receiving_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

`ifdef MAPLE_RX_CRC_EN
  logic [7:0] xor_q, xor_d;
  logic       chk_q, chk_d, crc_err_q, crc_err_d;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // Running packet XOR; checked only when the packet ended with a clean END pattern.
  always_comb begin
    if (state_q == ST_START && state_d == ST_DATA_A) begin
      xor_d = 8'h00;
    end else if (byte_done_s) begin
      xor_d = xor_fold(xor_q, byte_s);
    end else begin
      xor_d = xor_q;
    end
    if (state_q == ST_END && state_d == ST_FLUSH && !frame_err_d && enable) begin
      chk_d = 1'b1;
    end else if (state_q == ST_FLUSH && state_d == ST_IDLE) begin
      chk_d = 1'b0;
    end else begin
      chk_d = chk_q;
    end
    if (state_q == ST_FLUSH && hold_vld_q && out_free_s && chk_q && (xor_q != 8'h00)) begin
      crc_err_d = 1'b1;
    end else begin
      crc_err_d = 1'b0;
    end
  end

  // XOR accumulator and crc_err pulse register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      xor_q     <= 8'h00;
      chk_q     <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      chk_q     <= chk_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_maple_rx_decoder.sv
// Self-checking bench for maple_rx_decoder: directed scenarios plus random packets
// compared against a byte-level model (payload bytes, TLAST on last, XOR check).
module tb_maple_rx_decoder;

`ifdef MAPLE_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic aclk, aresetn, enable, sdcka, sdckb;
  logic receiving, frame_err, overrun, crc_err;
  maple_rx_decoder_if axis_if ();

  maple_rx_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .sdcka(sdcka), .sdckb(sdckb),
    .m_axis(axis_if), .receiving(receiving), .frame_err(frame_err),
    .overrun(overrun), .crc_err(crc_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total, bad;
  int frame_cnt, ovr_cnt, crc_cnt, rcv_cnt, axis_viol;
  int fe0, ov0, crc0, rc0, av0;
  bit ready_rand, ready_fix;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int got_rd, bit_idx;

  // Ready driver and observer: collects handshakes, error pulses and AXIS hold violations.
  initial begin
    logic stall_prev;
    logic [8:0] prev_beat;
    frame_cnt = 0; ovr_cnt = 0; crc_cnt = 0; rcv_cnt = 0; axis_viol = 0;
    stall_prev = 1'b0; prev_beat = 9'd0;
    axis_if.tready = 1'b1;
    forever begin
      @(posedge aclk); #2;
      axis_if.tready = ready_rand ? ($urandom_range(1, 0) == 1) : ready_fix;
      @(negedge aclk);
      if (!aresetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && (!axis_if.tvalid || {axis_if.tlast, axis_if.tdata} !== prev_beat))
          axis_viol++;
        if (axis_if.tvalid && axis_if.tready) got_q.push_back({axis_if.tlast, axis_if.tdata});
        stall_prev = axis_if.tvalid && !axis_if.tready;
        prev_beat  = {axis_if.tlast, axis_if.tdata};
        if (frame_err) frame_cnt++;
        if (overrun) ovr_cnt++;
        if (crc_err) crc_cnt++;
        if (receiving) rcv_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v);
    @(posedge aclk); #1; sdcka = v;
    repeat ($urandom_range(3, 1)) @(posedge aclk);
  endtask

  task automatic set_b(input logic v);
    @(posedge aclk); #1; sdckb = v;
    repeat ($urandom_range(3, 1)) @(posedge aclk);
  endtask

  task automatic send_start(input int pulses);
    bit_idx = 0;
    set_a(1'b0);
    for (int i = 0; i < pulses; i++) begin
      set_b(1'b0);
      if (i < pulses - 1) set_b(1'b1);
    end
    set_a(1'b1);
  endtask

  // Even bits are clocked by an A fall (data on B), odd bits by a B fall (data on A).
  task automatic send_bit(input logic v);
    if (bit_idx % 2 == 0) begin
      if (!sdcka) set_a(1'b1);
      if (sdckb !== v) set_b(v);
      set_a(1'b0);
    end else begin
      if (!sdckb) set_b(1'b1);
      if (sdcka !== v) set_a(v);
      set_b(1'b0);
    end
    bit_idx++;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(b[7-i]);
  endtask

  task automatic send_end();
    if (!sdcka) set_a(1'b1);
    set_b(1'b1);
    set_b(1'b0);
    set_a(1'b0); set_a(1'b1);
    set_a(1'b0); set_a(1'b1);
    set_b(1'b1);
  endtask

  task automatic send_packet(input logic [7:0] pkt[$]);
    send_start(4);
    foreach (pkt[i]) send_bits(pkt[i], 8);
    send_end();
  endtask

  task automatic lines_idle();
    if (!sdckb) set_b(1'b1);
    if (!sdcka) set_a(1'b1);
  endtask

  task automatic begin_test();
    fe0 = frame_cnt; ov0 = ovr_cnt; crc0 = crc_cnt; rc0 = rcv_cnt; av0 = axis_viol;
  endtask

  task automatic wait_beats(input int n, input int bound);
    int c;
    c = 0;
    while ((got_q.size() - got_rd) < n && c < bound) begin
      @(posedge aclk);
      c++;
    end
    repeat (20) @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic check_beats(input string tag);
    int n_new;
    n_new = got_q.size() - got_rd;
    check({tag, "_beats"}, n_new, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n_new) check($sformatf("%s_beat%0d", tag, i), got_q[got_rd+i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic end_test(input string tag, input int fe, input int ov, input int crc, input bit rcv_any);
    check_beats(tag);
    check({tag, "_frame_err"}, frame_cnt - fe0, fe);
    check({tag, "_overrun"}, ovr_cnt - ov0, ov);
    check({tag, "_crc_err"}, crc_cnt - crc0, crc);
    check({tag, "_rcv_seen"}, (rcv_cnt - rc0) != 0, rcv_any);
    check({tag, "_axis_hold"}, axis_viol - av0, 0);
    check({tag, "_rcv_idle"}, receiving, 1'b0);
  endtask

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] x;
    int n;
    total = 0; bad = 0; got_rd = 0; bit_idx = 0;
    aresetn = 1'b0; enable = 1'b1; sdcka = 1'b1; sdckb = 1'b1;
    ready_rand = 1'b0; ready_fix = 1'b1;

    repeat (4) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", axis_if.tvalid, 1'b0);
    check("rst_tdata", axis_if.tdata, 8'h00);
    check("rst_tlast", axis_if.tlast, 1'b0);
    check("rst_receiving", receiving, 1'b0);
    check("rst_flags", {frame_err, overrun, crc_err}, 3'b000);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    check("post_rst_tvalid", axis_if.tvalid, 1'b0);

    // 1: clean 3-byte packet, XOR of payload is zero
    begin_test();
    pkt = '{8'h0A, 8'h55, 8'h5F};
    exp_q = '{9'h00A, 9'h055, 9'h15F};
    send_packet(pkt);
    wait_beats(3, 200);
    end_test("t1", 0, 0, 0, 1'b1);

    // 2: XOR nonzero -> data delivered, crc_err pulse when enabled
    begin_test();
    pkt = '{8'h0A, 8'h55, 8'h5E};
    exp_q = '{9'h00A, 9'h055, 9'h15E};
    send_packet(pkt);
    wait_beats(3, 200);
    end_test("t2", 0, 0, CRC_ON ? 1 : 0, 1'b1);

    // 3: start pattern with three B pulses
    begin_test();
    send_start(3);
    repeat (10) @(posedge aclk);
    lines_idle();
    wait_beats(0, 0);
    end_test("t3", 1, 0, 0, 1'b0);

    // 4: stalled sink -> third byte dropped, then drain
    begin_test();
    ready_fix = 1'b0;
    pkt = '{8'h0A, 8'h55, 8'h5F};
    send_packet(pkt);
    wait_beats(0, 0);
    check_beats("t4_stalled");
    check("t4_rcv_in_flush", receiving, 1'b1);
    check("t4_tvalid_stalled", axis_if.tvalid, 1'b1);
    ready_fix = 1'b1;
    exp_q = '{9'h00A, 9'h155};
    wait_beats(2, 100);
    end_test("t4", 0, 1, 0, 1'b1);

    // 5: lines freeze after 12 bits -> timeout abort closes framing
    begin_test();
    send_start(4);
    send_bits(8'hA5, 8);
    send_bits(8'hC0, 4);
    exp_q = '{9'h1A5};
    wait_beats(1, 1500);
    lines_idle();
    wait_beats(0, 0);
    end_test("t5", 1, 0, 0, 1'b1);

    // 6: enable drop mid-byte2, then a packet while disabled is ignored
    begin_test();
    send_start(4);
    send_bits(8'h3C, 8);
    send_bits(8'h81, 3);
    @(posedge aclk); #1 enable = 1'b0;
    exp_q = '{9'h13C};
    wait_beats(1, 100);
    lines_idle();
    end_test("t6_drop", 0, 0, 0, 1'b1);
    begin_test();
    pkt = '{8'h12, 8'h34};
    send_packet(pkt);
    wait_beats(0, 0);
    end_test("t6_disabled", 0, 0, 0, 1'b0);
    @(posedge aclk); #1 enable = 1'b1;
    repeat (5) @(posedge aclk);

    // Random packets with a randomly stalling sink
    ready_rand = 1'b1;
    for (int p = 0; p < 6; p++) begin
      begin_test();
      n = $urandom_range(5, 1);
      pkt.delete();
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        pkt.push_back(8'($urandom));
        x = x ^ pkt[i];
        exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, pkt[i]});
      end
      send_packet(pkt);
      wait_beats(n, 400);
      end_test($sformatf("rnd%0d", p), 0, 0, (CRC_ON && x != 8'h00) ? 1 : 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
